noise_source_gauss: RTL and testbench



---
 rtl/noise_source_gauss.sv | 92 +++++++++
 tb/tb_noise_source_gauss.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/noise_source_gauss.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : noise_source_gauss                                              |
// | Summary  : Irwin-Hall (n=4) Gaussian-like noise from four 32-bit Galois     |
// |            LFSRs, 2-stage adder pipeline, programmable decimation.          |
// | Revision : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
module noise_source_gauss #(
  parameter logic [31:0] SEED0 = 32'h0000_0001,
  parameter logic [31:0] SEED1 = 32'h0000_2000,
  parameter logic [31:0] SEED2 = 32'hFFFF_FFFF,
  parameter logic [31:0] SEED3 = 32'h1234_5678
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [15:0] div_i,
  input  logic        seed_load_i,
  input  logic [1:0]  seed_sel_i,
  input  logic [31:0] seed_i,
  output logic [15:0] data_o,
  output logic        valid_o
);

  localparam logic [31:0] c_poly = 32'h8020_0003;

  logic [15:0]       r_cnt;
  logic [14:0]       r_p0;
  logic [14:0]       r_p1;
  logic              r_v1;
  logic              w_tick;
  logic [3:0][13:0]  w_u;

  // Greater-or-equal compare so lowering div_i below the count never locks up.
  assign w_tick = en_i && (r_cnt >= div_i);

  generate
    for (genvar k = 0; k < 4; k++) begin : g_lfsr
      localparam logic [31:0] c_seed = (k == 0) ? SEED0 :
                                       (k == 1) ? SEED1 :
                                       (k == 2) ? SEED2 : SEED3;
      logic [31:0] r_state;
      logic        w_load;

      assign w_load = seed_load_i && (seed_sel_i == 2'(k));
      assign w_u[k] = r_state[13:0];

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          r_state <= c_seed;
        end else if (w_load) begin
          r_state <= (seed_i == 32'd0) ? c_seed : seed_i;
        end else if (w_tick) begin
          r_state <= (r_state >> 1) ^ (r_state[0] ? c_poly : 32'd0);
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= 16'd0;
    end else if (w_tick) begin
      r_cnt <= 16'd0;
    end else if (en_i) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // Manual sign extension keeps the adders explicitly sized.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_p0    <= 15'd0;
      r_p1    <= 15'd0;
      r_v1    <= 1'b0;
      data_o  <= 16'd0;
      valid_o <= 1'b0;
    end else begin
      r_v1 <= w_tick;
      if (w_tick) begin
        r_p0 <= {w_u[0][13], w_u[0]} + {w_u[1][13], w_u[1]};
        r_p1 <= {w_u[2][13], w_u[2]} + {w_u[3][13], w_u[3]};
      end
      valid_o <= r_v1;
      if (r_v1) begin
        data_o <= {r_p0[14], r_p0} + {r_p1[14], r_p1};
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_noise_source_gauss.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_noise_source_gauss                                           |
// | Summary  : Scoreboard bench for noise_source_gauss against a sample model.  |
// | Revision : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
module tb_noise_source_gauss;

  typedef struct {
    logic [15:0] data;
    int          edge_n;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        en_i = 1'b0;
  logic [15:0] div_i = 16'd0;
  logic        seed_load_i = 1'b0;
  logic [1:0]  seed_sel_i = 2'd0;
  logic [31:0] seed_i = 32'd0;
  logic [15:0] data_o;
  logic        valid_o;

  int          checks = 0;
  int          errors = 0;
  int          edge_n = 0;
  exp_t        q[$];
  logic [15:0] exp_hold = 16'd0;
  logic [31:0] m_lfsr[4];
  int          m_cnt = 0;

  noise_source_gauss dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .en_i        (en_i),
    .div_i       (div_i),
    .seed_load_i (seed_load_i),
    .seed_sel_i  (seed_sel_i),
    .seed_i      (seed_i),
    .data_o      (data_o),
    .valid_o     (valid_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) edge_n++;

  function automatic logic [31:0] seed_of(input int k);
    case (k)
      0:       return 32'h0000_0001;
      1:       return 32'h0000_2000;
      2:       return 32'hFFFF_FFFF;
      default: return 32'h1234_5678;
    endcase
  endfunction

  function automatic int uterm(input logic [31:0] s);
    logic signed [13:0] t;
    t = s[13:0];
    return int'(t);
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'd0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) m_lfsr[k] = seed_of(k);
    m_cnt = 0;
    q.delete();
    exp_hold = 16'd0;
  endtask

  // Applies the current inputs to the model for the coming edge.
  task automatic model_step();
    bit tick;
    int sum;
    exp_t e;
    tick = en_i && (m_cnt >= int'(div_i));
    if (tick) begin
      sum = 0;
      for (int k = 0; k < 4; k++) sum += uterm(m_lfsr[k]);
      e.data   = sum[15:0];
      e.edge_n = edge_n + 2;
      q.push_back(e);
    end
    for (int k = 0; k < 4; k++) begin
      if (seed_load_i && int'(seed_sel_i) == k)
        m_lfsr[k] = (seed_i == 32'd0) ? seed_of(k) : seed_i;
      else if (tick)
        m_lfsr[k] = lfsr_next(m_lfsr[k]);
    end
    if (tick) m_cnt = 0;
    else if (en_i) m_cnt++;
  endtask

  task automatic cyc(input bit en, input int div, input bit ld = 1'b0,
                     input int sel = 0, input logic [31:0] seed = 32'd0);
    en_i        = en;
    div_i       = 16'(div);
    seed_load_i = ld;
    seed_sel_i  = 2'(sel);
    seed_i      = seed;
    model_step();
    @(negedge clk_i);
    #1;
  endtask

  // Monitor: pops the scoreboard on each strobe, checks timing and hold.
  always @(negedge clk_i) begin
    exp_t e;
    if (!rst_i) begin
      if (valid_o) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL strobe: unexpected valid_o at edge %0d data_o=%h required no strobe", edge_n, data_o);
        end else begin
          e = q.pop_front();
          chk("strobe_edge", 32'(edge_n), 32'(e.edge_n));
          chk("sample", {16'd0, data_o}, {16'd0, e.data});
          exp_hold = e.data;
        end
      end else begin
        if (q.size() != 0 && q[0].edge_n <= edge_n) begin
          checks++;
          errors++;
          $display("FAIL strobe: valid_o=0 at edge %0d required 1 data %h", edge_n, q[0].data);
          void'(q.pop_front());
        end
        chk("hold", {16'd0, data_o}, {16'd0, exp_hold});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    int pulses;
    model_reset();
    repeat (3) @(negedge clk_i);
    #1;
    chk("reset_data", {16'd0, data_o}, 32'd0);
    chk("reset_valid", {31'd0, valid_o}, 32'd0);
    rst_i = 1'b0;

    // First sample from default seeds.
    cyc(1, 0);
    cyc(1, 0);
    chk("first_valid", {31'd0, valid_o}, 32'd1);
    chk("first_sample", {16'd0, data_o}, 32'h0000_F678);
    repeat (5) cyc(1, 0);

    // Extremes: all seeds 0x2000 and 0x1FFF.
    for (int k = 0; k < 4; k++) cyc(0, 0, 1'b1, k, 32'h0000_2000);
    cyc(1, 0);
    cyc(1, 0);
    chk("min_sample", {16'd0, data_o}, 32'h0000_8000);
    for (int k = 0; k < 4; k++) cyc(0, 0, 1'b1, k, 32'h0000_1FFF);
    cyc(1, 0);
    cyc(1, 0);
    chk("max_sample", {16'd0, data_o}, 32'h0000_7FFC);

    // Decimation by 4.
    cyc(1, 3);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1, 3);
      pulses += int'(valid_o);
    end
    chk("div3_pulses", 32'(pulses), 32'd5);

    // Enable dropped right after a tick, then resumed.
    repeat (3) cyc(1, 0);
    repeat (6) cyc(0, 0);
    repeat (4) cyc(1, 1);

    // Zero seed on LFSR2 coinciding with a tick.
    cyc(1, 0, 1'b1, 2, 32'd0);
    repeat (4) cyc(1, 0);

    // Randomised run.
    for (int i = 0; i < 400; i++) begin
      bit en, ld;
      int div;
      logic [31:0] sd;
      en  = ($urandom_range(0, 3) != 0);
      div = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 5));
      ld  = ($urandom_range(0, 19) == 0);
      sd  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      cyc(en, div, ld, int'($urandom_range(0, 3)), sd);
    end

    // Asynchronous reset while a strobe is visible.
    repeat (3) cyc(1, 0);
    chk("pre_reset_valid", {31'd0, valid_o}, 32'd1);
    rst_i = 1'b1;
    en_i  = 1'b0;
    seed_load_i = 1'b0;
    #1;
    chk("async_rst_data", {16'd0, data_o}, 32'd0);
    chk("async_rst_valid", {31'd0, valid_o}, 32'd0);
    model_reset();
    @(negedge clk_i);
    #1;
    rst_i = 1'b0;
    cyc(1, 0);
    chk("post_reset_no_strobe", {31'd0, valid_o}, 32'd0);
    cyc(1, 0);
    chk("post_reset_sample", {16'd0, data_o}, 32'h0000_F678);

    repeat (4) cyc(0, 0);
    chk("scoreboard_empty", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
